message_sequencer: RTL and testbench

MESSAGE_SEQUENCER -- requirements
Module: message_sequencer

---
 rtl/message_sequencer.sv | 132 +++++++++++++
 tb/tb_message_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/message_sequencer.sv
// Message sequencer: walks a latched message through an external cipher one character at a time.
// Optional build macro MSG_SEQ_CASEFOLD_EN presents lowercase letters to the cipher as uppercase.
module message_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [79:0] message,
    input  logic [3:0]  length,
    output logic [7:0]  plainChar,
    output logic        cipherLoad,
    output logic        cipherStep,
    input  logic [7:0]  cipherChar,
    output logic [79:0] result,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // state   | meaning
    // IDLE    | waiting for start; flags idle
    // LOAD    | one-cycle cipher load pulse, index cleared
    // EMIT    | present char[index] on plainChar
    // CAPTURE | hold char, step cipher, store cipherChar into result slot
    // DONE    | one-cycle done pulse
    typedef enum logic [2:0] {IDLE, LOAD, EMIT, CAPTURE, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  len_q, len_d;
    logic [79:0] msg_q, msg_d;
    logic [79:0] result_q, result_d;
    logic        error_q, error_d;

    logic [7:0]  cur_char;
    logic [7:0]  emit_char;
    logic [3:0]  idx_inc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            len_q    <= 4'd0;
            msg_q    <= 80'd0;
            result_q <= 80'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            msg_q    <= msg_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        cur_char = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (idx_q == 4'(i)) cur_char = msg_q[79-8*i -: 8];
        end
    end

`ifdef MSG_SEQ_CASEFOLD_EN
    assign emit_char = (cur_char >= 8'h61 && cur_char <= 8'h7A) ? (cur_char - 8'h20) : cur_char;
`else
    assign emit_char = cur_char;
`endif

    assign idx_inc = idx_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        msg_d      = msg_q;
        result_d   = result_q;
        error_d    = error_q;
        plainChar  = 8'h00;
        cipherLoad = 1'b0;
        cipherStep = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (length != 4'd0 && length <= 4'd10) begin
                        msg_d    = message;
                        len_d    = length;
                        result_d = 80'd0;
                        error_d  = 1'b0;
                        state_d  = LOAD;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                cipherLoad = 1'b1;
                idx_d      = 4'd0;
                state_d    = EMIT;
            end
            EMIT: begin
                plainChar = emit_char;
                state_d   = CAPTURE;
            end
            CAPTURE: begin
                plainChar  = emit_char;
                cipherStep = 1'b1;
                // result always keeps the cipher output verbatim, never the folded char
                for (int i = 0; i < 10; i++) begin
                    if (idx_q == 4'(i)) result_d[79-8*i -: 8] = cipherChar;
                end
                idx_d   = idx_inc;
                state_d = (idx_inc == len_q) ? DONE : EMIT;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign result = result_q;
    assign error  = error_q;

endmodule

// File: tb/tb_message_sequencer.sv
// Self-checking bench for message_sequencer: directed cases plus random messages through a
// Caesar/Vigenere cipher environment, compared against a whole-message reference model.
module tb_message_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [79:0] message;
    logic [3:0]  length;
    logic [7:0]  plainChar;
    logic        cipherLoad;
    logic        cipherStep;
    logic [7:0]  cipherChar;
    logic [79:0] result;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [7:0] key [10];
    int         kp;

    message_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .message    (message),
        .length     (length),
        .plainChar  (plainChar),
        .cipherLoad (cipherLoad),
        .cipherStep (cipherStep),
        .cipherChar (cipherChar),
        .result     (result),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] enc(input logic [7:0] p, input logic [7:0] k);
        int v;
        if (p >= 8'h41 && p <= 8'h5A) begin
            v = (int'(p) - 65 + int'(k) - 65) % 26 + 65;
            return 8'(v);
        end
        return p;
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef MSG_SEQ_CASEFOLD_EN
        if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
        return c;
    endfunction

    // cipher environment: key position restarts on load, advances on every step
    always @(posedge clock or posedge reset) begin
        if (reset)           kp <= 0;
        else if (cipherLoad) kp <= 0;
        else if (cipherStep) kp <= (kp == 9) ? 0 : kp + 1;
    end

    always_comb cipherChar = enc(plainChar, key[kp]);

    // char i of any message meets key position i, since each capture steps the key once
    function automatic logic [79:0] model(input logic [79:0] msg, input int len);
        logic [79:0] r;
        r = 80'd0;
        for (int i = 0; i < len; i++)
            r[79-8*i -: 8] = enc(fold(msg[79-8*i -: 8]), key[i]);
        return r;
    endfunction

    function automatic logic [79:0] rand_msg();
        logic [79:0] m;
        for (int i = 0; i < 10; i++) m[8*i +: 8] = 8'($urandom_range(32, 126));
        return m;
    endfunction

    task automatic set_key(input string s);
        for (int i = 0; i < 10; i++) key[i] = s[i];
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_msg(input logic [79:0] msg, input int len, input int restart_at);
        logic [79:0] exp;
        int loads, steps, done_at, c;
        exp = model(msg, len);
        @(negedge clock);
        message = msg;
        length  = 4'(len);
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        c = 1; loads = 0; steps = 0; done_at = -1;
        while (c < 30 && done_at < 0) begin
            start = (c == restart_at);
            if (c == restart_at) begin
                message = rand_msg();
                length  = 4'($urandom_range(1, 10));
            end
            if (cipherLoad) loads++;
            if (cipherStep) steps++;
            chk("busy_active", 80'(busy), 80'(1));
            chk("load_step_excl", 80'(cipherLoad & cipherStep), 80'(0));
            if (c == 1) chk("load_cycle", 80'(cipherLoad), 80'(1));
            if (c >= 2 && c <= 1 + 2 * len) begin
                chk("plain_char", 80'(plainChar), 80'(fold(msg[79-8*((c-2)/2) -: 8])));
                chk("step_phase", 80'(cipherStep), 80'(c % 2));
            end
            if (done) done_at = c;
            @(negedge clock);
            c++;
        end
        start = 1'b0;
        chk("done_cycle", 80'(done_at), 80'(2 + 2 * len));
        chk("load_count", 80'(loads), 80'(1));
        chk("step_count", 80'(steps), 80'(len));
        chk("result", result, exp);
        chk("idle_busy", 80'(busy), 80'(0));
        chk("idle_plain", 80'(plainChar), 80'(0));
        repeat (3) @(negedge clock);
        chk("result_hold", result, exp);
    endtask

    task automatic bad_start(input int len);
        logic [79:0] prev;
        int pulses;
        prev = result;
        pulses = 0;
        @(negedge clock);
        message = rand_msg();
        length  = 4'(len);
        start   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (cipherLoad || cipherStep) pulses++;
            chk("err_busy", 80'(busy), 80'(0));
        end
        chk("err_flag", 80'(error), 80'(1));
        chk("err_pulses", 80'(pulses), 80'(0));
        chk("err_result", result, prev);
    endtask

    initial begin
        logic [79:0] m;
        int steps;
        reset   = 1'b1;
        start   = 1'b0;
        message = 80'd0;
        length  = 4'd0;
        set_key("KADIROZLEM");
        #1;
        chk("rst_busy",   80'(busy), 80'(0));
        chk("rst_done",   80'(done), 80'(0));
        chk("rst_error",  80'(error), 80'(0));
        chk("rst_plain",  80'(plainChar), 80'(0));
        chk("rst_load",   80'(cipherLoad), 80'(0));
        chk("rst_step",   80'(cipherStep), 80'(0));
        chk("rst_result", result, 80'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        run_msg({"ISTANBUL", 16'h0}, 8, -1);
        chk("vigenere_const", result, {"SSWIEPTW", 16'h0});

        set_key("DDDDDDDDDD");
        run_msg({"A", 72'h0}, 1, -1);
        chk("caesar_const", 80'(result[79:72]), 80'("D"));

        bad_start(0);
        bad_start(11);
        bad_start(15);

        set_key("KADIROZLEM");
        run_msg(rand_msg(), 10, 9);
        chk("err_cleared", 80'(error), 80'(0));

        run_msg({"ab", 64'h0}, 2, -1);

        // asynchronous reset in the middle of the 3rd EMIT
        m = rand_msg();
        @(negedge clock);
        message = m; length = 4'd10; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        chk("pre_rst_plain", 80'(plainChar), 80'(fold(m[63:56])));
        #2 reset = 1'b1;
        #1;
        chk("arst_busy",   80'(busy), 80'(0));
        chk("arst_plain",  80'(plainChar), 80'(0));
        chk("arst_result", result, 80'd0);
        chk("arst_load",   80'(cipherLoad), 80'(0));
        chk("arst_step",   80'(cipherStep), 80'(0));
        chk("arst_done",   80'(done), 80'(0));
        chk("arst_error",  80'(error), 80'(0));
        @(negedge clock);
        reset = 1'b0;
        steps = 0;
        repeat (4) begin
            @(negedge clock);
            if (cipherStep || cipherLoad) steps++;
        end
        chk("arst_no_pulses", 80'(steps), 80'(0));
        run_msg(rand_msg(), 2, -1);

        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1) set_key("DDDDDDDDDD");
            else set_key("KADIROZLEM");
            run_msg(rand_msg(), int'($urandom_range(1, 10)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
